lin_frame_decoder: RTL and testbench
====================================

LIN_FRAME_DECODER -- requirements
Module: lin_frame_decoder

Interface
REQ-001 Parameters SHALL be:
- EVT_ID, 6'h10: event-triggered frame ID.
- UNC_SUB_ID, 6'h11: unconditional frame; master publishes, slave subscribes.
- UNC_PUB_ID, 6'h12: unconditional frame; slave publishes.
- TIMEOUT, 16'd2000: maximum clocks between accepted bytes inside a frame.

REQ-002 Ports SHALL be:
- clk in 1: the single clock.
- reset in 1: synchronous, active-high.
- brk_det in 1: pulse, break field detected.
- rx_valid in 1: pulse, rx_byte valid.
- rx_byte in 8: received byte.
- rx_err in 1: pulse, UART framing error.
- MASTER_REQ out 1: pulse, valid header received.
- FRAME_TYPE out 2: 00 unconditional, 01 diagnostic, 10 event-triggered, 11 none.
- master_publisher out 1, master_subscriber out 1: frame direction.
- MASTER_REQ_frame out 1: level, valid diagnostic master request.
- NAD1 out 4: NAD from master request.
- SLEEP_CMD out 1: pulse, go-to-sleep frame received.
- rx_data out 64: received data, byte0 in [7:0].
- DATA_VALID out 1: pulse, rx_data valid.
- chk_err out 1: pulse, checksum mismatch.
- pid_err out 1: pulse, PID parity mismatch.

Function
REQ-003 FSM states SHALL be IDLE, SYNC, PID, DATA, CHK.
- IDLE→SYNC on brk_det.
- SYNC→PID on byte 0x55; any other sync byte→IDLE.
- PID: on accepted byte→DATA or IDLE per REQ-004..006.
- DATA→CHK after 8th data byte.
- CHK→IDLE on checksum byte.

REQ-004 PID parity SHALL be P0=ID0^ID1^ID2^ID4 (bit6) and P1=~(ID1^ID3^ID4^ID5) (bit7). On mismatch: pid_err pulse, →IDLE, MASTER_REQ not asserted.

REQ-005 Valid PID SHALL pulse MASTER_REQ exactly 1 cycle, in the cycle after the PID byte is accepted. FRAME_TYPE, master_publisher and master_subscriber SHALL be registered in that same cycle and held until the next valid PID or reset.

REQ-006 ID decode SHALL be:
- 0x3C: type 01, pub=1/sub=0, →DATA.
- 0x3D: type 01, pub=0/sub=1, →IDLE.
- EVT_ID: type 10, pub=1/sub=0, →DATA.
- UNC_SUB_ID: type 00, pub=1/sub=0, →DATA.
- UNC_PUB_ID: type 00, pub=0/sub=1, →IDLE.
- Any other ID: no MASTER_REQ, outputs unchanged, →IDLE.

REQ-007 Data length SHALL be fixed at 8 bytes. Byte n SHALL be stored at rx_data[8n+7:8n]. rx_data SHALL be updated only on checksum pass.

REQ-008 Checksum SHALL be an 8-bit sum with carry added back in (end-around carry), then inverted.
- IDs 0x3C/0x3D use classic checksum (data only).
- All other IDs use enhanced checksum (PID + data).

REQ-009 On checksum pass, DATA_VALID SHALL pulse 1 cycle, in the cycle after the checksum byte. On mismatch: chk_err pulse, no DATA_VALID, no SLEEP_CMD, rx_data and MASTER_REQ_frame unchanged.

REQ-010 For a passing ID 0x3C frame:
- byte0 == 0x00: SLEEP_CMD pulse with DATA_VALID; MASTER_REQ_frame=0.
- byte0 != 0x00: MASTER_REQ_frame=1 and NAD1=byte0[3:0].

REQ-011 MASTER_REQ_frame SHALL clear on the next brk_det.

REQ-012 brk_det in any non-IDLE state SHALL abort the current frame with no outputs and enter SYNC in the next cycle.

REQ-013 rx_err in any state SHALL →IDLE with no outputs; rx_err SHALL take priority over a simultaneous rx_valid. brk_det SHALL take priority over both.

REQ-014 A gap counter SHALL reset on every accepted byte and on entry to SYNC. If it reaches TIMEOUT in SYNC, PID, DATA or CHK: →IDLE, no outputs, partial data discarded.

REQ-015 rx_valid in IDLE SHALL be ignored.

Reset
REQ-016 reset SHALL force, at the next clk edge:
- state IDLE; gap counter, byte counter and checksum accumulator 0.
- MASTER_REQ, MASTER_REQ_frame, SLEEP_CMD, DATA_VALID, chk_err, pid_err = 0.
- FRAME_TYPE=2'b11; master_publisher=0, master_subscriber=0; NAD1=0; rx_data=0.

REQ-017 reset mid-frame SHALL discard the frame with no pulses.

Verification
REQ-018 Sleep frame: brk, 0x55, 0x3C, 0x00, 7×0xFF, chk 0x00 → MASTER_REQ with FRAME_TYPE=01; then SLEEP_CMD=1 and DATA_VALID=1 for 1 cycle; MASTER_REQ_frame=0.

REQ-019 Master request: brk, 0x55, 0x3C, 0x05, 0x06, 0xB2, 5×0xFF, correct classic chk → MASTER_REQ_frame=1, NAD1=4'h5; next brk_det clears MASTER_REQ_frame.

REQ-020 Enhanced checksum, ID 0x11: brk, 0x55, 0x11, 8×0x00, chk 0xEE → DATA_VALID, rx_data=0. Same frame with chk 0x11 → chk_err pulse, no DATA_VALID.

REQ-021 Parity: PID 0x50 (ID 0x10) → MASTER_REQ, FRAME_TYPE=10, then data phase. PID 0x10 → pid_err pulse, no MASTER_REQ, state IDLE.

REQ-022 Abort:
- brk_det after 3 data bytes → SYNC next cycle, no DATA_VALID.
- No byte for TIMEOUT clocks in DATA → IDLE.
- reset asserted in CHK → all outputs at REQ-016 values.

Source files
------------

// File: rtl/lin_frame_decoder.sv
// LIN slave frame decoder: break/sync/PID header, 8-byte data phase, checksum,
// diagnostic master-request and go-to-sleep extraction.
module lin_frame_decoder #(
    parameter logic [5:0]  EVT_ID     = 6'h10,
    parameter logic [5:0]  UNC_SUB_ID = 6'h11,
    parameter logic [5:0]  UNC_PUB_ID = 6'h12,
    parameter logic [15:0] TIMEOUT    = 16'd2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        brk_det,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_err,
    output logic        MASTER_REQ,
    output logic [1:0]  FRAME_TYPE,
    output logic        master_publisher,
    output logic        master_subscriber,
    output logic        MASTER_REQ_frame,
    output logic [3:0]  NAD1,
    output logic        SLEEP_CMD,
    output logic [63:0] rx_data,
    output logic        DATA_VALID,
    output logic        chk_err,
    output logic        pid_err
);

    localparam int unsigned DATA_BYTES = 8;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned GAP_W      = 16;
    localparam logic [5:0]  DIAG_REQ_ID = 6'h3C;
    localparam logic [5:0]  DIAG_RSP_ID = 6'h3D;
    localparam logic [7:0]  SYNC_BYTE   = 8'h55;
    localparam logic [1:0]  FT_UNC  = 2'b00;
    localparam logic [1:0]  FT_DIAG = 2'b01;
    localparam logic [1:0]  FT_EVT  = 2'b10;
    localparam logic [1:0]  FT_NONE = 2'b11;

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CHK} state_t;

    state_t             r_state, w_state_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]         r_sum, w_sum_nxt;
    logic               r_diag_req, w_diag_req_nxt;
    logic [63:0]        r_buf, w_buf_nxt;

    logic               r_master_req, w_master_req_nxt;
    logic [1:0]         r_frame_type, w_frame_type_nxt;
    logic               r_pub, w_pub_nxt;
    logic               r_sub, w_sub_nxt;
    logic               r_mrf, w_mrf_nxt;
    logic [3:0]         r_nad, w_nad_nxt;
    logic               r_sleep, w_sleep_nxt;
    logic [63:0]        r_rx_data, w_rx_data_nxt;
    logic               r_dv, w_dv_nxt;
    logic               r_chk_err, w_chk_err_nxt;
    logic               r_pid_err, w_pid_err_nxt;

    logic [5:0]         w_id;
    logic               w_par_ok;
    logic [8:0]         w_sum_add;
    logic [7:0]         w_sum_acc;
    logic               w_timeout;

    logic               w_hit;
    logic [1:0]         w_ft;
    logic               w_pub;
    logic               w_sub;
    logic               w_to_data;
    logic               w_classic;

    assign w_id     = rx_byte[5:0];
    assign w_par_ok = (rx_byte[6] == (rx_byte[0] ^ rx_byte[1] ^ rx_byte[2] ^ rx_byte[4])) &&
                      (rx_byte[7] == ~(rx_byte[1] ^ rx_byte[3] ^ rx_byte[4] ^ rx_byte[5]));
    // End-around carry add; the folded result cannot overflow a second time.
    assign w_sum_add = 9'(r_sum) + 9'(rx_byte);
    assign w_sum_acc = w_sum_add[7:0] + 8'(w_sum_add[8]);
    assign w_timeout = (r_gap >= TIMEOUT);

    // Frame-ID classification of the received PID byte
    always_comb begin
        w_hit     = 1'b1;
        w_ft      = FT_NONE;
        w_pub     = 1'b0;
        w_sub     = 1'b0;
        w_to_data = 1'b0;
        w_classic = 1'b0;
        case (w_id)
            DIAG_REQ_ID: begin w_ft = FT_DIAG; w_pub = 1'b1; w_to_data = 1'b1; w_classic = 1'b1; end
            DIAG_RSP_ID: begin w_ft = FT_DIAG; w_sub = 1'b1; w_classic = 1'b1; end
            EVT_ID:      begin w_ft = FT_EVT;  w_pub = 1'b1; w_to_data = 1'b1; end
            UNC_SUB_ID:  begin w_ft = FT_UNC;  w_pub = 1'b1; w_to_data = 1'b1; end
            UNC_PUB_ID:  begin w_ft = FT_UNC;  w_sub = 1'b1; end
            default:     w_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gap_nxt        = (r_state == IDLE) ? '0 : r_gap + GAP_W'(1);
        w_cnt_nxt        = r_cnt;
        w_sum_nxt        = r_sum;
        w_diag_req_nxt   = r_diag_req;
        w_buf_nxt        = r_buf;
        w_master_req_nxt = 1'b0;
        w_frame_type_nxt = r_frame_type;
        w_pub_nxt        = r_pub;
        w_sub_nxt        = r_sub;
        w_mrf_nxt        = r_mrf;
        w_nad_nxt        = r_nad;
        w_sleep_nxt      = 1'b0;
        w_rx_data_nxt    = r_rx_data;
        w_dv_nxt         = 1'b0;
        w_chk_err_nxt    = 1'b0;
        w_pid_err_nxt    = 1'b0;

        // Priority: break, then UART error, then inter-byte timeout, then data
        if (brk_det) begin
            w_state_nxt = SYNC;
            w_gap_nxt   = '0;
            w_mrf_nxt   = 1'b0;
        end else if (rx_err) begin
            w_state_nxt = IDLE;
            w_gap_nxt   = '0;
        end else if (r_state != IDLE && w_timeout) begin
            w_state_nxt = IDLE;
            w_gap_nxt   = '0;
        end else if (rx_valid) begin
            case (r_state)
                SYNC: begin
                    w_gap_nxt   = '0;
                    w_state_nxt = (rx_byte == SYNC_BYTE) ? PID : IDLE;
                end
                PID: begin
                    w_gap_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (!w_par_ok) begin
                        w_pid_err_nxt = 1'b1;
                    end else if (w_hit) begin
                        w_master_req_nxt = 1'b1;
                        w_frame_type_nxt = w_ft;
                        w_pub_nxt        = w_pub;
                        w_sub_nxt        = w_sub;
                        w_cnt_nxt        = '0;
                        w_sum_nxt        = w_classic ? 8'h00 : rx_byte;
                        w_diag_req_nxt   = (w_id == DIAG_REQ_ID);
                        if (w_to_data) w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    w_gap_nxt = '0;
                    w_buf_nxt[{r_cnt, 3'b000} +: 8] = rx_byte;
                    w_sum_nxt = w_sum_acc;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_BYTES - 1)) w_state_nxt = CHK;
                end
                CHK: begin
                    w_gap_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (rx_byte == ~r_sum) begin
                        w_dv_nxt      = 1'b1;
                        w_rx_data_nxt = r_buf;
                        if (r_diag_req) begin
                            if (r_buf[7:0] == 8'h00) begin
                                w_sleep_nxt = 1'b1;
                                w_mrf_nxt   = 1'b0;
                            end else begin
                                w_mrf_nxt = 1'b1;
                                w_nad_nxt = r_buf[3:0];
                            end
                        end
                    end else begin
                        w_chk_err_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_gap        <= '0;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_diag_req   <= 1'b0;
            r_buf        <= '0;
            r_master_req <= 1'b0;
            r_frame_type <= FT_NONE;
            r_pub        <= 1'b0;
            r_sub        <= 1'b0;
            r_mrf        <= 1'b0;
            r_nad        <= '0;
            r_sleep      <= 1'b0;
            r_rx_data    <= '0;
            r_dv         <= 1'b0;
            r_chk_err    <= 1'b0;
            r_pid_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gap        <= w_gap_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sum        <= w_sum_nxt;
            r_diag_req   <= w_diag_req_nxt;
            r_buf        <= w_buf_nxt;
            r_master_req <= w_master_req_nxt;
            r_frame_type <= w_frame_type_nxt;
            r_pub        <= w_pub_nxt;
            r_sub        <= w_sub_nxt;
            r_mrf        <= w_mrf_nxt;
            r_nad        <= w_nad_nxt;
            r_sleep      <= w_sleep_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_dv         <= w_dv_nxt;
            r_chk_err    <= w_chk_err_nxt;
            r_pid_err    <= w_pid_err_nxt;
        end
    end

    assign MASTER_REQ        = r_master_req;
    assign FRAME_TYPE        = r_frame_type;
    assign master_publisher  = r_pub;
    assign master_subscriber = r_sub;
    assign MASTER_REQ_frame  = r_mrf;
    assign NAD1              = r_nad;
    assign SLEEP_CMD         = r_sleep;
    assign rx_data           = r_rx_data;
    assign DATA_VALID        = r_dv;
    assign chk_err           = r_chk_err;
    assign pid_err           = r_pid_err;

endmodule

// File: tb/tb_lin_frame_decoder.sv
// Directed bench for lin_frame_decoder: hand-computed frames, checksums and aborts.
module tb_lin_frame_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        brk_det;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_err;
    logic        MASTER_REQ;
    logic [1:0]  FRAME_TYPE;
    logic        master_publisher;
    logic        master_subscriber;
    logic        MASTER_REQ_frame;
    logic [3:0]  NAD1;
    logic        SLEEP_CMD;
    logic [63:0] rx_data;
    logic        DATA_VALID;
    logic        chk_err;
    logic        pid_err;

    int n_assert = 0;
    int n_fail   = 0;

    lin_frame_decoder dut (
        .clk               (clk),
        .reset             (reset),
        .brk_det           (brk_det),
        .rx_valid          (rx_valid),
        .rx_byte           (rx_byte),
        .rx_err            (rx_err),
        .MASTER_REQ        (MASTER_REQ),
        .FRAME_TYPE        (FRAME_TYPE),
        .master_publisher  (master_publisher),
        .master_subscriber (master_subscriber),
        .MASTER_REQ_frame  (MASTER_REQ_frame),
        .NAD1              (NAD1),
        .SLEEP_CMD         (SLEEP_CMD),
        .rx_data           (rx_data),
        .DATA_VALID        (DATA_VALID),
        .chk_err           (chk_err),
        .pid_err           (pid_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic brk();
        brk_det = 1'b1;
        step();
        brk_det = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        brk_det  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        rx_err   = 1'b0;
        idle(2);
        check("rst_mreq",  64'(MASTER_REQ), 64'd0);
        check("rst_ftype", 64'(FRAME_TYPE), 64'd3);
        check("rst_pub",   64'(master_publisher), 64'd0);
        check("rst_sub",   64'(master_subscriber), 64'd0);
        check("rst_mrf",   64'(MASTER_REQ_frame), 64'd0);
        check("rst_nad",   64'(NAD1), 64'd0);
        check("rst_data",  rx_data, 64'd0);
        check("rst_dv",    64'(DATA_VALID), 64'd0);
        reset = 1'b0;
        step();

        // Go-to-sleep frame
        brk(); send(8'h55); send(8'h3C);
        check("slp_mreq",  64'(MASTER_REQ), 64'd1);
        check("slp_ftype", 64'(FRAME_TYPE), 64'd1);
        check("slp_pub",   64'(master_publisher), 64'd1);
        check("slp_sub",   64'(master_subscriber), 64'd0);
        send(8'h00);
        check("slp_mreq_pulse", 64'(MASTER_REQ), 64'd0);
        repeat (7) send(8'hFF);
        send(8'h00);
        check("slp_sleep", 64'(SLEEP_CMD), 64'd1);
        check("slp_dv",    64'(DATA_VALID), 64'd1);
        check("slp_mrf",   64'(MASTER_REQ_frame), 64'd0);
        check("slp_data",  rx_data, 64'hFFFF_FFFF_FFFF_FF00);
        step();
        check("slp_sleep_pulse", 64'(SLEEP_CMD), 64'd0);
        check("slp_dv_pulse",    64'(DATA_VALID), 64'd0);

        // Diagnostic master request, classic checksum 0x42
        brk(); send(8'h55); send(8'h3C);
        send(8'h05); send(8'h06); send(8'hB2);
        repeat (5) send(8'hFF);
        send(8'h42);
        check("mrq_dv",    64'(DATA_VALID), 64'd1);
        check("mrq_mrf",   64'(MASTER_REQ_frame), 64'd1);
        check("mrq_nad",   64'(NAD1), 64'h5);
        check("mrq_sleep", 64'(SLEEP_CMD), 64'd0);
        check("mrq_data",  rx_data, 64'hFFFF_FFFF_FFB2_0605);
        brk();
        check("mrq_mrf_clr", 64'(MASTER_REQ_frame), 64'd0);

        // Enhanced checksum, ID 0x11, bad checksum first (still in SYNC)
        send(8'h55); send(8'h11);
        check("enh_mreq",  64'(MASTER_REQ), 64'd1);
        check("enh_ftype", 64'(FRAME_TYPE), 64'd0);
        check("enh_pub",   64'(master_publisher), 64'd1);
        repeat (8) send(8'h00);
        send(8'h11);
        check("enh_bad_chkerr", 64'(chk_err), 64'd1);
        check("enh_bad_dv",     64'(DATA_VALID), 64'd0);
        check("enh_bad_data",   rx_data, 64'hFFFF_FFFF_FFB2_0605);
        brk(); send(8'h55); send(8'h11);
        repeat (8) send(8'h00);
        send(8'hEE);
        check("enh_dv",     64'(DATA_VALID), 64'd1);
        check("enh_chkerr", 64'(chk_err), 64'd0);
        check("enh_data",   rx_data, 64'd0);

        // PID 0x50 (event ID 0x10), then break after 3 data bytes
        brk(); send(8'h55); send(8'h50);
        check("evt_mreq",  64'(MASTER_REQ), 64'd1);
        check("evt_ftype", 64'(FRAME_TYPE), 64'd2);
        check("evt_pub",   64'(master_publisher), 64'd1);
        send(8'h01); send(8'h02); send(8'h03);
        brk();
        check("abrt_dv",     64'(DATA_VALID), 64'd0);
        check("abrt_chkerr", 64'(chk_err), 64'd0);
        // Decoder must now be in SYNC: a header completes without another break
        send(8'h55); send(8'h92);
        check("abrt_sync_mreq", 64'(MASTER_REQ), 64'd1);
        check("pub12_ftype",    64'(FRAME_TYPE), 64'd0);
        check("pub12_pub",      64'(master_publisher), 64'd0);
        check("pub12_sub",      64'(master_subscriber), 64'd1);
        // Slave-publish ID returns to IDLE, where bytes are ignored
        send(8'h55); send(8'h3C);
        check("idle_ignore", 64'(MASTER_REQ), 64'd0);

        // Parity error on raw 0x10
        brk(); send(8'h55); send(8'h10);
        check("par_piderr", 64'(pid_err), 64'd1);
        check("par_mreq",   64'(MASTER_REQ), 64'd0);
        check("par_ftype",  64'(FRAME_TYPE), 64'd0);
        send(8'h3C);
        check("par_idle",   64'(MASTER_REQ), 64'd0);
        check("par_pulse",  64'(pid_err), 64'd0);

        // Unknown ID 0x01 (PID 0xC1): no request, outputs held
        brk(); send(8'h55); send(8'hC1);
        check("unk_mreq",   64'(MASTER_REQ), 64'd0);
        check("unk_piderr", 64'(pid_err), 64'd0);
        check("unk_sub",    64'(master_subscriber), 64'd1);

        // Diagnostic slave response ID 0x3D (PID 0x7D)
        brk(); send(8'h55); send(8'h7D);
        check("rsp_mreq",  64'(MASTER_REQ), 64'd1);
        check("rsp_ftype", 64'(FRAME_TYPE), 64'd1);
        check("rsp_pub",   64'(master_publisher), 64'd0);
        check("rsp_sub",   64'(master_subscriber), 64'd1);

        // Inter-byte gap below timeout is tolerated; checksum 0xA7
        brk(); send(8'h55); send(8'h50);
        repeat (3) send(8'h01);
        idle(50);
        repeat (5) send(8'h01);
        send(8'hA7);
        check("gap_ok_dv",   64'(DATA_VALID), 64'd1);
        check("gap_ok_data", rx_data, 64'h0101_0101_0101_0101);

        // Gap beyond timeout discards the frame
        brk(); send(8'h55); send(8'h50);
        repeat (2) send(8'h01);
        idle(2005);
        repeat (6) send(8'h01);
        send(8'hA7);
        check("tmo_dv",     64'(DATA_VALID), 64'd0);
        check("tmo_chkerr", 64'(chk_err), 64'd0);

        // UART error mid-frame
        brk(); send(8'h55); send(8'h3C);
        send(8'h05); send(8'h06);
        rx_err = 1'b1; step(); rx_err = 1'b0;
        send(8'hB2);
        repeat (5) send(8'hFF);
        send(8'h42);
        check("rxerr_dv",  64'(DATA_VALID), 64'd0);
        check("rxerr_mrf", 64'(MASTER_REQ_frame), 64'd0);

        // rx_err wins over a simultaneous sync byte
        brk();
        rx_err = 1'b1; rx_valid = 1'b1; rx_byte = 8'h55;
        step();
        rx_err = 1'b0; rx_valid = 1'b0;
        send(8'h3C);
        check("rxerr_prio", 64'(MASTER_REQ), 64'd0);

        // Reset while waiting for the checksum byte
        brk(); send(8'h55); send(8'h3C);
        send(8'h05); send(8'h06); send(8'hB2);
        repeat (5) send(8'hFF);
        reset = 1'b1; rx_valid = 1'b1; rx_byte = 8'h42;
        step();
        rx_valid = 1'b0;
        check("rchk_dv",    64'(DATA_VALID), 64'd0);
        check("rchk_mrf",   64'(MASTER_REQ_frame), 64'd0);
        check("rchk_nad",   64'(NAD1), 64'd0);
        check("rchk_ftype", 64'(FRAME_TYPE), 64'd3);
        check("rchk_pub",   64'(master_publisher), 64'd0);
        check("rchk_sub",   64'(master_subscriber), 64'd0);
        check("rchk_data",  rx_data, 64'd0);
        check("rchk_sleep", 64'(SLEEP_CMD), 64'd0);
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
